// File: rtl/mem_stage_ldq_pkg.sv
// Shared MEM-stage definitions: load-op bit positions, exception width,
// queue entry layout and the MS->WS bus field order.
package mem_stage_ldq_pkg;

  localparam int LD_W  = 0;
  localparam int LD_HU = 1;
  localparam int LD_H  = 2;
  localparam int LD_BU = 3;
  localparam int LD_B  = 4;

  localparam int EXC_W_DEF = 7;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] result;
    logic        rf_we;
    logic [4:0]  waddr;
    logic        rfm;
    logic [4:0]  ld_op;
    logic        wt;
  } ms_ent_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
  } ms2ws_t;

endpackage

// File: rtl/mem_stage_ldq_if.sv
// EXE -> MEM handshake and op bus.
// master = EXE side, slave = MEM side.
interface mem_stage_ldq_if #(
  parameter int EXC_W = 7
) ();
  logic             es2ms_valid;
  logic             ms_allowin;
  logic [31:0]      es_pc;
  logic [31:0]      es_result;
  logic             es_rf_we;
  logic [4:0]       es_rf_waddr;
  logic             es_res_from_mem;
  logic [4:0]       es_ld_op;
  logic             es_wait_data_ok;
  logic [EXC_W-1:0] es_exc;

  modport master (
    output es2ms_valid, es_pc, es_result,
    output es_rf_we, es_rf_waddr,
    output es_res_from_mem, es_ld_op,
    output es_wait_data_ok, es_exc,
    input  ms_allowin
  );

  modport slave (
    input  es2ms_valid, es_pc, es_result,
    input  es_rf_we, es_rf_waddr,
    input  es_res_from_mem, es_ld_op,
    input  es_wait_data_ok, es_exc,
    output ms_allowin
  );
endinterface

// File: rtl/mem_stage_ldq_align.sv
// Load data alignment: byte-lane shift then sign/zero extension.
// Shared by the WB head path and the ID bypass path.
module ms_load_align
  import mem_stage_ldq_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [4:0]  ld_op,
  output logic [31:0] aligned
);
  logic [31:0] sh;

  assign sh = rdata >> {off, 3'b000};

  always_comb begin
    aligned = sh;
    unique case (1'b1)
      ld_op[LD_B]:  aligned = {{24{sh[7]}}, sh[7:0]};
      ld_op[LD_BU]: aligned = {24'b0, sh[7:0]};
      ld_op[LD_H]:  aligned = {{16{sh[15]}}, sh[15:0]};
      ld_op[LD_HU]: aligned = {16'b0, sh[15:0]};
      default:      aligned = sh;
    endcase
  end
endmodule

// File: rtl/mem_stage_ldq.sv
// MEM stage load queue: DEPTH in-order ops with outstanding data_sram
// responses. MS_BYPASS_EN enables query forwarding (else stall-only).
module mem_stage_ldq
  import mem_stage_ldq_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int NUM_QRY = 2,
  parameter int EXC_W   = EXC_W_DEF
) (
  input  logic                 clk,
  input  logic                 resetn,
  mem_stage_ldq_if.slave       es,
  input  logic                 data_sram_data_ok,
  input  logic [31:0]          data_sram_rdata,
  input  logic                 ws_allowin,
  output logic                 ms2ws_valid,
  output logic [31:0]          ms_pc,
  output logic                 ms_rf_we,
  output logic [4:0]           ms_rf_waddr,
  output logic [31:0]          ms_rf_wdata,
  output logic [EXC_W-1:0]     ms_exc,
  output logic                 ms_ex,
  input  logic                 wb_ex,
  input  logic [5*NUM_QRY-1:0] qry_raddr,
  output logic [NUM_QRY-1:0]   qry_hit,
  output logic [NUM_QRY-1:0]   qry_ready,
  output logic [32*NUM_QRY-1:0] qry_data
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1) + 1;

  ms_ent_t          ent [DEPTH];
  logic [EXC_W-1:0] exc [DEPTH];
  logic [31:0]      dat [DEPTH];
  logic [DEPTH-1:0] got;

  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, drop_cnt, pend;
  logic [PW-1:0] slot [DEPTH];
  logic [DEPTH-1:0] live;
  logic [PW-1:0] tgt;
  logic          tgt_found, take, drop_hit;
  logic          q_ne, push, pop;
  ms_ent_t       hd;
  logic [31:0]   head_src, head_al;
  ms2ws_t        wsb;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // slot[k] is the k-th oldest entry
  for (genvar k = 0; k < DEPTH; k++) begin : g_age
    assign slot[k] = PW'((32'(rd_ptr) + k) % DEPTH);
    assign live[k] = CW'(k) < count;
  end

  always_comb begin
    tgt_found = 1'b0;
    tgt       = '0;
    pend      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (live[k] && ent[slot[k]].wt
          && !got[slot[k]]) begin
        if (!tgt_found) tgt = slot[k];
        tgt_found = 1'b1;
        pend      = pend + CW'(1);
      end
    end
  end

  assign drop_hit = data_sram_data_ok
                  & (drop_cnt != '0);
  assign take     = data_sram_data_ok
                  & (drop_cnt == '0) & tgt_found;

  assign q_ne = count != '0;
  assign hd   = ent[rd_ptr];

  assign ms2ws_valid = q_ne & (~hd.wt
                     | got[rd_ptr]
                     | (take & (tgt == rd_ptr)));
  assign pop = ms2ws_valid & ws_allowin;

  assign es.ms_allowin =
    ((count + drop_cnt) < CW'(DEPTH)) | pop;
  assign push = es.es2ms_valid & es.ms_allowin
              & ~wb_ex;

  assign head_src = got[rd_ptr] ? dat[rd_ptr]
                                : data_sram_rdata;

  ms_load_align u_head_al (
    .rdata   (head_src),
    .off     (hd.result[1:0]),
    .ld_op   (hd.ld_op),
    .aligned (head_al)
  );

  always_comb begin
    wsb = '0;
    if (q_ne) begin
      wsb.pc       = hd.pc;
      wsb.rf_we    = hd.rf_we;
      wsb.rf_waddr = hd.waddr;
      wsb.rf_wdata = hd.rfm ? head_al : hd.result;
    end
  end

  assign ms_pc       = wsb.pc;
  assign ms_rf_we    = wsb.rf_we;
  assign ms_rf_waddr = wsb.rf_waddr;
  assign ms_rf_wdata = wsb.rf_wdata;
  assign ms_exc      = q_ne ? exc[rd_ptr] : '0;
  assign ms_ex       = q_ne & (|exc[rd_ptr]);

  // response lands before the flush retires its target
  always_ff @(posedge clk) begin
    if (!resetn) begin
      count    <= '0;
      drop_cnt <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      got      <= '0;
    end else begin
      drop_cnt <= drop_cnt - CW'(drop_hit)
                + (wb_ex ? pend - CW'(take) : '0);
      if (take) got[tgt] <= 1'b1;
      if (wb_ex) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (pop) rd_ptr <= nxt(rd_ptr);
        if (push) begin
          wr_ptr      <= nxt(wr_ptr);
          got[wr_ptr] <= 1'b0;
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (take) dat[tgt] <= data_sram_rdata;
    if (push) begin
      ent[wr_ptr] <= '{
        pc:     es.es_pc,
        result: es.es_result,
        rf_we:  es.es_rf_we,
        waddr:  es.es_rf_waddr,
        rfm:    es.es_res_from_mem,
        ld_op:  es.es_ld_op,
        wt:     es.es_wait_data_ok & ~(|es.es_exc)
      };
      exc[wr_ptr] <= es.es_exc;
    end
  end

  for (genvar i = 0; i < NUM_QRY; i++) begin : g_qry
    logic [4:0] ra;
    logic       hit_i;
`ifdef MS_BYPASS_EN
    logic [PW-1:0] sel;
    logic [31:0]   al;
`endif

    assign ra = qry_raddr[5*i +: 5];

    // later (younger) matches override older ones
    always_comb begin
      hit_i = 1'b0;
`ifdef MS_BYPASS_EN
      sel = '0;
`endif
      for (int k = 0; k < DEPTH; k++) begin
        if (live[k] && ent[slot[k]].rf_we
            && ent[slot[k]].waddr == ra
            && ra != 5'd0) begin
          hit_i = 1'b1;
`ifdef MS_BYPASS_EN
          sel = slot[k];
`endif
        end
      end
    end

    assign qry_hit[i] = hit_i;

`ifdef MS_BYPASS_EN
    ms_load_align u_qry_al (
      .rdata   (dat[sel]),
      .off     (ent[sel].result[1:0]),
      .ld_op   (ent[sel].ld_op),
      .aligned (al)
    );
    assign qry_ready[i] = hit_i
      & (~ent[sel].rfm | got[sel]);
    assign qry_data[32*i +: 32] = !hit_i ? '0
      : ent[sel].rfm ? al : ent[sel].result;
`else
    assign qry_ready[i] = 1'b0;
    assign qry_data[32*i +: 32] = '0;
`endif
  end
endmodule

// File: tb/tb_mem_stage_ldq.sv
// Directed scenarios plus a randomized run against a queue-based
// reference model of the MEM load queue.
module tb_mem_stage_ldq;
  import mem_stage_ldq_pkg::*;

  localparam int DEPTH = 2;
  localparam int NQ    = 2;
  localparam int EW    = 7;
`ifdef MS_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  mem_stage_ldq_if #(.EXC_W(EW)) es ();

  logic          data_ok;
  logic [31:0]   rdata;
  logic          ws_allowin;
  logic          ms2ws_valid;
  logic [31:0]   ms_pc;
  logic          ms_rf_we;
  logic [4:0]    ms_rf_waddr;
  logic [31:0]   ms_rf_wdata;
  logic [EW-1:0] ms_exc;
  logic          ms_ex;
  logic          wb_ex;
  logic [5*NQ-1:0]  qry_raddr;
  logic [NQ-1:0]    qry_hit;
  logic [NQ-1:0]    qry_ready;
  logic [32*NQ-1:0] qry_data;

  mem_stage_ldq #(
    .DEPTH(DEPTH), .NUM_QRY(NQ), .EXC_W(EW)
  ) dut (
    .clk               (clk),
    .resetn            (resetn),
    .es                (es),
    .data_sram_data_ok (data_ok),
    .data_sram_rdata   (rdata),
    .ws_allowin        (ws_allowin),
    .ms2ws_valid       (ms2ws_valid),
    .ms_pc             (ms_pc),
    .ms_rf_we          (ms_rf_we),
    .ms_rf_waddr       (ms_rf_waddr),
    .ms_rf_wdata       (ms_rf_wdata),
    .ms_exc            (ms_exc),
    .ms_ex             (ms_ex),
    .wb_ex             (wb_ex),
    .qry_raddr         (qry_raddr),
    .qry_hit           (qry_hit),
    .qry_ready         (qry_ready),
    .qry_data          (qry_data)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] res;
    bit          we;
    logic [4:0]  wa;
    bit          rfm;
    logic [4:0]  op;
    logic [6:0]  exc;
    bit          wt;
    bit          got;
    logic [31:0] data;
  } mop_t;

  function automatic logic [31:0] ref_ext(
    input logic [31:0] d, input logic [1:0] off,
    input logic [4:0] op);
    logic [31:0] v;
    int b;
    v = d >> (8 * int'(off));
    if (op[LD_B] || op[LD_BU]) begin
      b = int'(v & 32'hFF);
      if (op[LD_B] && b >= 128) b -= 256;
      return 32'(b);
    end
    if (op[LD_H] || op[LD_HU]) begin
      b = int'(v & 32'hFFFF);
      if (op[LD_H] && b >= 32768) b -= 65536;
      return 32'(b);
    end
    return v;
  endfunction

  task automatic idle();
    es.es2ms_valid     = 1'b0;
    es.es_pc           = '0;
    es.es_result       = '0;
    es.es_rf_we        = 1'b0;
    es.es_rf_waddr     = '0;
    es.es_res_from_mem = 1'b0;
    es.es_ld_op        = '0;
    es.es_wait_data_ok = 1'b0;
    es.es_exc          = '0;
    data_ok    = 1'b0;
    rdata      = '0;
    ws_allowin = 1'b0;
    wb_ex      = 1'b0;
    qry_raddr  = '0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_op(
    input logic [31:0] pc, input logic [31:0] res,
    input logic [4:0] wa, input logic rfm,
    input logic [4:0] op, input logic wt,
    input logic [6:0] ex);
    es.es2ms_valid     = 1'b1;
    es.es_pc           = pc;
    es.es_result       = res;
    es.es_rf_we        = 1'b1;
    es.es_rf_waddr     = wa;
    es.es_res_from_mem = rfm;
    es.es_ld_op        = op;
    es.es_wait_data_ok = wt;
    es.es_exc          = ex;
  endtask

  task automatic rst();
    idle();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    rst();
    #1;
    checks++;
    if (ms2ws_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got=%0h exp=0",
               ms2ws_valid);
    end
    checks++;
    if (ms_ex !== 1'b0) begin
      failures++;
      $display("FAIL reset_ex got=%0h exp=0", ms_ex);
    end
    checks++;
    if (qry_hit !== '0 || qry_ready !== '0) begin
      failures++;
      $display("FAIL reset_qry hit=%0h rdy=%0h exp=0",
               qry_hit, qry_ready);
    end
    checks++;
    if (ms_pc !== '0 || ms_rf_wdata !== '0) begin
      failures++;
      $display("FAIL reset_data pc=%0h wd=%0h exp=0",
               ms_pc, ms_rf_wdata);
    end
    checks++;
    if (es.ms_allowin !== 1'b1) begin
      failures++;
      $display("FAIL reset_allowin got=%0h exp=1",
               es.ms_allowin);
    end
  endtask

  task automatic test_align();
    rst();
    tick();
    set_op(32'h1000, 32'h201, 5'd3, 1'b1,
           5'(1 << LD_B), 1'b1, '0);
    tick();
    idle();
    data_ok = 1'b1;
    rdata = 32'h0000_80FF;
    ws_allowin = 1'b1;
    #1;
    checks++;
    if (ms2ws_valid !== 1'b1
        || ms_rf_wdata !== 32'hFFFF_FF80
        || ms_pc !== 32'h1000) begin
      failures++;
      $display("FAIL align_ldb v=%0h wd=%0h pc=%0h exp=1 ffffff80 1000",
               ms2ws_valid, ms_rf_wdata, ms_pc);
    end
    tick();
    idle();
    set_op(32'h1004, 32'h201, 5'd3, 1'b1,
           5'(1 << LD_BU), 1'b1, '0);
    tick();
    idle();
    data_ok = 1'b1;
    rdata = 32'h0000_80FF;
    ws_allowin = 1'b1;
    #1;
    checks++;
    if (ms2ws_valid !== 1'b1
        || ms_rf_wdata !== 32'h0000_0080) begin
      failures++;
      $display("FAIL align_ldbu v=%0h wd=%0h exp=1 80",
               ms2ws_valid, ms_rf_wdata);
    end
    tick();
    idle();
  endtask

  task automatic test_in_order();
    rst();
    tick();
    set_op(32'h10, 32'h100, 5'd1, 1'b1,
           5'(1 << LD_W), 1'b1, '0);
    tick();
    set_op(32'h14, 32'h104, 5'd2, 1'b1,
           5'(1 << LD_W), 1'b1, '0);
    #1;
    checks++;
    if (es.ms_allowin !== 1'b1) begin
      failures++;
      $display("FAIL order_allow1 got=%0h exp=1",
               es.ms_allowin);
    end
    tick();
    idle();
    #1;
    checks++;
    if (es.ms_allowin !== 1'b0 || ms2ws_valid !== 1'b0) begin
      failures++;
      $display("FAIL order_full allow=%0h v=%0h exp=0 0",
               es.ms_allowin, ms2ws_valid);
    end
    tick();
    data_ok = 1'b1;
    rdata = 32'h11;
    ws_allowin = 1'b1;
    #1;
    checks++;
    if (ms2ws_valid !== 1'b1 || ms_rf_wdata !== 32'h11
        || ms_rf_waddr !== 5'd1) begin
      failures++;
      $display("FAIL order_first v=%0h wd=%0h wa=%0d exp=1 11 1",
               ms2ws_valid, ms_rf_wdata, ms_rf_waddr);
    end
    tick();
    rdata = 32'h22;
    #1;
    checks++;
    if (ms2ws_valid !== 1'b1 || ms_rf_wdata !== 32'h22
        || ms_rf_waddr !== 5'd2) begin
      failures++;
      $display("FAIL order_second v=%0h wd=%0h wa=%0d exp=1 22 2",
               ms2ws_valid, ms_rf_wdata, ms_rf_waddr);
    end
    tick();
    idle();
    #1;
    checks++;
    if (ms2ws_valid !== 1'b0) begin
      failures++;
      $display("FAIL order_empty got=%0h exp=0", ms2ws_valid);
    end
  endtask

  task automatic test_flush();
    rst();
    tick();
    set_op(32'h20, 32'h100, 5'd1, 1'b1,
           5'(1 << LD_W), 1'b1, '0);
    tick();
    set_op(32'h24, 32'h104, 5'd2, 1'b1,
           5'(1 << LD_W), 1'b1, '0);
    tick();
    idle();
    wb_ex = 1'b1;
    tick();
    idle();
    #1;
    checks++;
    if (es.ms_allowin !== 1'b0 || ms2ws_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_drop2 allow=%0h v=%0h exp=0 0",
               es.ms_allowin, ms2ws_valid);
    end
    data_ok = 1'b1;
    rdata = 32'hAA;
    tick();
    idle();
    #1;
    checks++;
    if (es.ms_allowin !== 1'b1) begin
      failures++;
      $display("FAIL flush_drop1 allow=%0h exp=1",
               es.ms_allowin);
    end
    data_ok = 1'b1;
    rdata = 32'hBB;
    set_op(32'h28, 32'h200, 5'd3, 1'b1,
           5'(1 << LD_W), 1'b1, '0);
    tick();
    idle();
    #1;
    checks++;
    if (ms2ws_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_discard v=%0h exp=0", ms2ws_valid);
    end
    data_ok = 1'b1;
    rdata = 32'hCC;
    ws_allowin = 1'b1;
    #1;
    checks++;
    if (ms2ws_valid !== 1'b1 || ms_rf_wdata !== 32'hCC
        || ms_rf_waddr !== 5'd3) begin
      failures++;
      $display("FAIL flush_third v=%0h wd=%0h wa=%0d exp=1 cc 3",
               ms2ws_valid, ms_rf_wdata, ms_rf_waddr);
    end
    tick();
    idle();
  endtask

  task automatic test_flush_same_cycle();
    rst();
    tick();
    set_op(32'h30, 32'h100, 5'd1, 1'b1,
           5'(1 << LD_W), 1'b1, '0);
    tick();
    set_op(32'h34, 32'h104, 5'd2, 1'b1,
           5'(1 << LD_W), 1'b1, '0);
    tick();
    idle();
    wb_ex = 1'b1;
    data_ok = 1'b1;
    rdata = 32'h55;
    tick();
    idle();
    #1;
    checks++;
    if (es.ms_allowin !== 1'b1) begin
      failures++;
      $display("FAIL same_drop1 allow=%0h exp=1", es.ms_allowin);
    end
    set_op(32'h38, 32'h300, 5'd4, 1'b1,
           5'(1 << LD_W), 1'b1, '0);
    tick();
    idle();
    #1;
    checks++;
    if (es.ms_allowin !== 1'b0 || ms2ws_valid !== 1'b0) begin
      failures++;
      $display("FAIL same_block allow=%0h v=%0h exp=0 0",
               es.ms_allowin, ms2ws_valid);
    end
    tick();
    #1;
    checks++;
    if (es.ms_allowin !== 1'b0) begin
      failures++;
      $display("FAIL same_hold allow=%0h exp=0", es.ms_allowin);
    end
    data_ok = 1'b1;
    rdata = 32'h66;
    #1;
    checks++;
    if (ms2ws_valid !== 1'b0) begin
      failures++;
      $display("FAIL same_discard v=%0h exp=0", ms2ws_valid);
    end
    tick();
    idle();
    #1;
    checks++;
    if (es.ms_allowin !== 1'b1) begin
      failures++;
      $display("FAIL same_release allow=%0h exp=1",
               es.ms_allowin);
    end
    data_ok = 1'b1;
    rdata = 32'h77;
    ws_allowin = 1'b1;
    #1;
    checks++;
    if (ms2ws_valid !== 1'b1 || ms_rf_wdata !== 32'h77) begin
      failures++;
      $display("FAIL same_new v=%0h wd=%0h exp=1 77",
               ms2ws_valid, ms_rf_wdata);
    end
    tick();
    idle();
  endtask

  task automatic test_query();
    logic [31:0] exp_d;
    rst();
    tick();
    set_op(32'h40, 32'h300, 5'd5, 1'b1,
           5'(1 << LD_W), 1'b1, '0);
    tick();
    idle();
    qry_raddr = {5'd6, 5'd5};
    #1;
    checks++;
    if (qry_hit !== 2'b01 || qry_ready[0] !== 1'b0) begin
      failures++;
      $display("FAIL qry_pending hit=%0h rdy=%0h exp=1 0",
               qry_hit, qry_ready);
    end
    data_ok = 1'b1;
    rdata = 32'h1234;
    tick();
    idle();
    qry_raddr = {5'd6, 5'd5};
    exp_d = BYP ? 32'h1234 : 32'h0;
    #1;
    checks++;
    if (qry_hit[0] !== 1'b1 || qry_ready[0] !== BYP
        || qry_data[31:0] !== exp_d) begin
      failures++;
      $display("FAIL qry_ready hit=%0h rdy=%0h d=%0h exp=1 %0h %0h",
               qry_hit[0], qry_ready[0], qry_data[31:0],
               BYP, exp_d);
    end
    checks++;
    if (ms2ws_valid !== 1'b1) begin
      failures++;
      $display("FAIL qry_head v=%0h exp=1", ms2ws_valid);
    end
    ws_allowin = 1'b1;
    tick();
    idle();
    qry_raddr = {5'd6, 5'd5};
    #1;
    checks++;
    if (qry_hit !== 2'b00) begin
      failures++;
      $display("FAIL qry_gone hit=%0h exp=0", qry_hit);
    end
  endtask

  task automatic test_exc();
    rst();
    tick();
    set_op(32'h400, 32'h0, 5'd7, 1'b0,
           5'd0, 1'b0, 7'h04);
    tick();
    idle();
    #1;
    checks++;
    if (ms_ex !== 1'b1 || ms2ws_valid !== 1'b1
        || ms_exc !== 7'h04) begin
      failures++;
      $display("FAIL exc_head ex=%0h v=%0h exc=%0h exp=1 1 4",
               ms_ex, ms2ws_valid, ms_exc);
    end
    ws_allowin = 1'b1;
    tick();
    idle();
    #1;
    checks++;
    if (ms_ex !== 1'b0 || ms2ws_valid !== 1'b0) begin
      failures++;
      $display("FAIL exc_pop ex=%0h v=%0h exp=0 0",
               ms_ex, ms2ws_valid);
    end
  endtask

  task automatic test_random();
    mop_t q[$];
    mop_t t;
    int drop, pend, tgt, kind, hj;
    bit take, e_v, e_pop, e_allow, e_push, e_ex;
    bit hit, e_rdy;
    logic [31:0] e_wd, e_qd;
    logic [4:0] ra;
    rst();
    drop = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      tick();
      pend = drop;
      foreach (q[j]) if (q[j].wt && !q[j].got) pend++;
      data_ok = (pend > 0) && ($urandom_range(0, 2) != 0);
      rdata = $urandom;
      ws_allowin = $urandom_range(0, 3) != 0;
      wb_ex = $urandom_range(0, 29) == 0;
      kind = $urandom_range(0, 3);
      es.es2ms_valid = 1'($urandom_range(0, 1));
      es.es_pc = $urandom;
      es.es_result = $urandom;
      es.es_rf_we = 1'b1;
      es.es_rf_waddr = 5'($urandom_range(0, 7));
      es.es_res_from_mem = 1'b0;
      es.es_ld_op = '0;
      es.es_wait_data_ok = 1'b0;
      es.es_exc = '0;
      if (kind == 1) begin
        es.es_res_from_mem = 1'b1;
        es.es_wait_data_ok = 1'b1;
        es.es_ld_op = 5'(1 << $urandom_range(0, 4));
      end else if (kind == 2) begin
        es.es_rf_we = 1'b0;
        es.es_wait_data_ok = 1'b1;
      end else if (kind == 3) begin
        es.es_exc = 7'($urandom_range(1, 127));
        es.es_rf_we = 1'($urandom_range(0, 1));
      end
      qry_raddr = {5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7))};
      #1;
      tgt = -1;
      foreach (q[j])
        if (tgt < 0 && q[j].wt && !q[j].got) tgt = j;
      take = data_ok && drop == 0 && tgt >= 0;
      e_v = q.size() > 0 && (!q[0].wt || q[0].got
            || (take && tgt == 0));
      e_pop = e_v && ws_allowin;
      e_allow = (q.size() + drop < DEPTH) || e_pop;
      e_push = es.es2ms_valid && e_allow && !wb_ex;
      e_ex = q.size() > 0 && q[0].exc != 0;
      checks++;
      if (es.ms_allowin !== e_allow
          || ms2ws_valid !== e_v || ms_ex !== e_ex) begin
        failures++;
        $display("FAIL rnd_ctl cyc=%0d allow=%0h v=%0h ex=%0h exp=%0h %0h %0h",
                 cyc, es.ms_allowin, ms2ws_valid, ms_ex,
                 e_allow, e_v, e_ex);
      end
      if (e_v) begin
        e_wd = q[0].rfm
          ? ref_ext(q[0].got ? q[0].data : rdata,
                    q[0].res[1:0], q[0].op)
          : q[0].res;
        checks++;
        if (ms_rf_wdata !== e_wd || ms_pc !== q[0].pc
            || ms_rf_waddr !== q[0].wa
            || ms_rf_we !== q[0].we
            || ms_exc !== q[0].exc) begin
          failures++;
          $display("FAIL rnd_head cyc=%0d wd=%0h pc=%0h wa=%0d exp=%0h %0h %0d",
                   cyc, ms_rf_wdata, ms_pc, ms_rf_waddr,
                   e_wd, q[0].pc, q[0].wa);
        end
      end
      for (int i = 0; i < NQ; i++) begin
        ra = qry_raddr[5*i +: 5];
        hit = 1'b0;
        hj = 0;
        foreach (q[j])
          if (q[j].we && q[j].wa == ra && ra != 0) begin
            hit = 1'b1;
            hj = j;
          end
        e_rdy = BYP && hit && (!q[hj].rfm || q[hj].got);
        e_qd = '0;
        if (e_rdy)
          e_qd = q[hj].rfm
            ? ref_ext(q[hj].data, q[hj].res[1:0], q[hj].op)
            : q[hj].res;
        checks++;
        if (qry_hit[i] !== hit || qry_ready[i] !== e_rdy
            || ((!BYP || e_rdy)
                && qry_data[32*i +: 32] !== e_qd)) begin
          failures++;
          $display("FAIL rnd_qry cyc=%0d i=%0d hit=%0h rdy=%0h d=%0h exp=%0h %0h %0h",
                   cyc, i, qry_hit[i], qry_ready[i],
                   qry_data[32*i +: 32], hit, e_rdy, e_qd);
        end
      end
      if (data_ok) begin
        if (drop > 0) drop--;
        else if (tgt >= 0) begin
          t = q[tgt];
          t.got = 1'b1;
          t.data = rdata;
          q[tgt] = t;
        end
      end
      if (wb_ex) begin
        foreach (q[j]) if (q[j].wt && !q[j].got) drop++;
        q.delete();
      end else begin
        if (e_pop) void'(q.pop_front());
        if (e_push) begin
          t.pc = es.es_pc;
          t.res = es.es_result;
          t.we = es.es_rf_we;
          t.wa = es.es_rf_waddr;
          t.rfm = es.es_res_from_mem;
          t.op = es.es_ld_op;
          t.exc = es.es_exc;
          t.wt = es.es_wait_data_ok && es.es_exc == 0;
          t.got = 1'b0;
          t.data = '0;
          q.push_back(t);
        end
      end
    end
    tick();
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    idle();
    resetn = 1'b0;
    test_reset();
    test_align();
    test_in_order();
    test_flush();
    test_flush_same_cycle();
    test_query();
    test_exc();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
